// File: rtl/fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared encodings for the fetch-stage sequencing controller: PC select
// codes, instruction-load select codes, FSM states, BIOS port owners and the
// default address-region nibbles.
// ---------------------------------------------------------------------------
package fetch_ctrl_pkg;

  // Next-PC source selected in stage_fetch.
  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_JUMP   = 2'b01;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b10;

  // Source of the instruction word handed to decode one cycle later.
  localparam logic [1:0] ILOAD_IMEM   = 2'b00;
  localparam logic [1:0] ILOAD_BIOS   = 2'b01;
  localparam logic [1:0] ILOAD_BUBBLE = 2'b10;

  // fetch_pc[31:28] values that select each instruction memory.
  localparam logic [3:0] BIOS_REGION_DEF = 4'h4;
  localparam logic [3:0] IMEM_REGION_DEF = 4'h1;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_REDIRECT = 2'd2
  } fetch_state_e;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } bios_owner_e;

  // Map an address region onto the memory whose read data decode will see.
  function automatic logic [1:0] region_iload(input logic [3:0] region,
                                              input logic [3:0] bios_region,
                                              input logic [3:0] imem_region);
    if (region == bios_region)      return ILOAD_BIOS;
    else if (region == imem_region) return ILOAD_IMEM;
    else                            return ILOAD_BUBBLE;
  endfunction

endpackage

// File: rtl/fetch_bios_arb.sv
// ---------------------------------------------------------------------------
// fetch_bios_arb
// Arbitrates the single BIOS read port between instruction fetch and
// data-side loads. On a conflict the port alternates between the two
// requesters, so a persistent data request can never starve fetch (and
// vice versa). A data request without a fetch conflict is always granted.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   data_en         data grants allowed (low while the controller boots)
//   fetch_bios      fetch needs the BIOS port this cycle
//   dbios_req       data side wants to read BIOS this cycle
//   grant_data      BIOS port owned by the data side this cycle
//   data_wait       data request not granted; data side must stall
//   fetch_blocked   fetch lost a conflict and must stall
// ---------------------------------------------------------------------------
module fetch_bios_arb
  import fetch_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic data_en,
  input  logic fetch_bios,
  input  logic dbios_req,
  output logic grant_data,
  output logic data_wait,
  output logic fetch_blocked
);

  bios_owner_e last_owner;
  logic        conflict;

  assign conflict      = fetch_bios & dbios_req;
  assign grant_data    = data_en & dbios_req &
                         (~fetch_bios | (last_owner == OWNER_FETCH));
  assign data_wait     = dbios_req & ~grant_data;
  assign fetch_blocked = conflict & grant_data;

  // Ownership only flips when both sides actually competed for the port.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the clock edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= OWNER_FETCH;
    end else if (conflict) begin
      last_owner <= (last_owner == OWNER_FETCH) ? OWNER_DATA : OWNER_FETCH;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Fetch-stage sequencing controller. Each cycle it chooses the next-PC
// source, decides whether fetch holds, kills the instruction entering decode
// after redirects, selects which memory feeds decode next cycle, shares the
// BIOS read port with data-side loads and counts fetch-stall cycles.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   fetch_pc         address presented to the instruction memories
//   ext_stall        downstream pipeline stall
//   jumpD            jump resolved in decode
//   branch_takenX    taken branch resolved in execute
//   dbios_req        data-side BIOS read this cycle
//   pc_sel           next-PC select (seq / jump / branch)
//   stallF           hold PC and iload_sel
//   flushD           kill the instruction entering decode
//   iload_sel        registered instruction source (IMEM / BIOS / bubble)
//   bios_grant_data  BIOS port owned by the data side this cycle
//   data_wait        data BIOS request not granted
//   stall_cnt        number of cycles with stallF high (wraps)
// ---------------------------------------------------------------------------
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned XLEN             = 32,
  parameter logic [3:0]  BIOS_REGION      = BIOS_REGION_DEF,
  parameter logic [3:0]  IMEM_REGION      = IMEM_REGION_DEF,
  parameter int unsigned REDIRECT_BUBBLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic            ext_stall,
  input  logic            jumpD,
  input  logic            branch_takenX,
  input  logic            dbios_req,
  output logic [1:0]      pc_sel,
  output logic            stallF,
  output logic            flushD,
  output logic [1:0]      iload_sel,
  output logic            bios_grant_data,
  output logic            data_wait,
  output logic [31:0]     stall_cnt
);

  localparam logic [2:0] BUB_RELOAD = 3'(REDIRECT_BUBBLES - 1);

  fetch_state_e state;
  logic [2:0]   bub_cnt;
  logic [3:0]   region;
  logic         redirect;
  logic         arb_en;
  logic         fetch_blocked;

  // Only the region nibble steers sequencing; the low PC bits are unused.
  logic unused_pc_bits;
  assign unused_pc_bits = ^fetch_pc[XLEN-5:0];

  assign region = fetch_pc[XLEN-1 -: 4];

  // Fetch competes for BIOS only in RUN when it is not being redirected.
  // While ext_stall holds the pipe, redirects wait, so fetch still competes.
  assign arb_en = (state == ST_RUN) &&
                  (ext_stall || !(branch_takenX || jumpD));

  fetch_bios_arb u_bios_arb (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_en       (state != ST_BOOT),
    .fetch_bios    (arb_en && (region == BIOS_REGION)),
    .dbios_req     (dbios_req),
    .grant_data    (bios_grant_data),
    .data_wait     (data_wait),
    .fetch_blocked (fetch_blocked)
  );

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    pc_sel   = PC_SEL_SEQ;
    stallF   = 1'b0;
    flushD   = 1'b0;
    redirect = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (ext_stall) begin
          stallF = 1'b1;
        end else if (branch_takenX) begin
          // The branch is older than a jump in decode; the jump dies here.
          pc_sel   = PC_SEL_BRANCH;
          flushD   = 1'b1;
          redirect = 1'b1;
        end else if (jumpD) begin
          pc_sel   = PC_SEL_JUMP;
          flushD   = 1'b1;
          redirect = 1'b1;
        end else begin
          stallF = fetch_blocked;
        end
      end
      ST_REDIRECT: begin
        flushD = 1'b1;
        if (ext_stall) begin
          stallF = 1'b1;
        end else if (branch_takenX) begin
          pc_sel   = PC_SEL_BRANCH;
          redirect = 1'b1;
        end
      end
      default: begin  // ST_BOOT
        stallF = 1'b1;
        flushD = 1'b1;
      end
    endcase
  end

  // NOTE: the reset branch puts every flop of the controller in a known
  // state; there is no storage array here that could be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_BOOT;
      bub_cnt   <= '0;
      iload_sel <= ILOAD_BUBBLE;
      stall_cnt <= '0;
    end else begin
      if (stallF) stall_cnt <= stall_cnt + 32'd1;

      unique case (state)
        ST_RUN: begin
          if (!ext_stall) begin
            if (redirect) begin
              iload_sel <= ILOAD_BUBBLE;
              if (REDIRECT_BUBBLES > 1) begin
                state   <= ST_REDIRECT;
                bub_cnt <= BUB_RELOAD;
              end
            end else if (fetch_blocked) begin
              // Data owns BIOS this cycle, so no instruction word arrives.
              iload_sel <= ILOAD_BUBBLE;
            end else begin
              iload_sel <= region_iload(region, BIOS_REGION, IMEM_REGION);
            end
          end
        end
        ST_REDIRECT: begin
          if (!ext_stall) begin
            iload_sel <= ILOAD_BUBBLE;
            if (redirect) begin
              bub_cnt <= BUB_RELOAD;
            end else begin
              bub_cnt <= bub_cnt - 3'd1;
              if (bub_cnt <= 3'd1) state <= ST_RUN;
            end
          end
        end
        default: begin  // ST_BOOT: exactly one cycle, inputs ignored
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule
